multicycle_controller: RTL and testbench

- Control FSM that sequences the shared RV32I datapath (PC, instruction register, regfile, ALU, unified memory) over multiple cycles per instruction.
- Decodes op/funct3/funct7b5 into per-cycle mux selects, write enables and ALUControl.
- Drives the same ALUControl/ImmSrc/ResultSrc encodings the single-cycle datapath uses.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

---
 rtl/multicycle_controller_if.sv | 58 +++++
 rtl/multicycle_controller.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Bundles the decode inputs and the control outputs exchanged between the
//   multicycle RV32I datapath and its control FSM.
//   Optional feature macro: MULTICYCLE_MEM_HANDSHAKE_EN (adds mem_ready).
//   Signals:
//     op/funct3/funct7b5/Zero  datapath -> controller (instruction fields, ALU zero)
//     mem_ready                datapath -> controller (only with the macro)
//     PCWrite..ALUControl      controller -> datapath (enables and mux selects)
//     illegal_instr            controller -> datapath (pulse on unsupported opcode)
//     state                    controller -> debug
//   Modports: master = datapath side, slave = controller side.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  logic               mem_ready;
`endif
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ImmSrc;
  logic [2:0]         ALUControl;
  logic               illegal_instr;
  logic [STATE_W-1:0] state;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  modport master (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
  );
  modport slave (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
  );
`else
  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
  );
  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state
  );
`endif
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM sequencing the shared RV32I datapath (lw, sw, R/I ALU, beq, jal)
//   over several cycles per instruction. All outputs are combinational
//   decodes of the current state and the instruction fields.
//   Optional feature macro: MULTICYCLE_MEM_HANDSHAKE_EN -- FETCH, MEMREAD and
//   MEMWRITE wait for mem_ready.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low
//     ctrl   multicycle_controller_if.slave (decode inputs, control outputs)
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   FETCH    | read instr at PC, PC <= PC+4, load IR/OldPC
//   DECODE   | read regs, ALUOut <= OldPC+imm (branch target)
//   MEMADR   | ALUOut <= rs1+imm
//   MEMREAD  | read memory at ALUOut
//   MEMWB    | rd <= Data
//   MEMWRITE | write rs2 to memory at ALUOut
//   EXECUTER | ALUOut <= rs1 op rs2
//   EXECUTEI | ALUOut <= rs1 op imm
//   ALUWB    | rd <= ALUOut
//   BEQ      | compare rs1/rs2, PC <= ALUOut if equal
//   JAL      | PC <= ALUOut, ALUOut <= OldPC+4
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave ctrl
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [STATE_W-1:0] state_q, state_d;
  logic               mem_rdy;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  assign mem_rdy = ctrl.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode
  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [2:0] alu_ctl, alu_dec;

  // funct3-driven ALU operation; sub only for R-type (op[5]) with bit 30 set
  always_comb begin
    alu_dec = 3'b000;
    case (ctrl.funct3)
      3'b000:  alu_dec = (ctrl.op[5] & ctrl.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    case (ctrl.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_write   = mem_rdy;
        pc_update  = mem_rdy;
        src_b      = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        illegal = !(ctrl.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_ctl = alu_dec;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_dec;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        src_a   = 2'b10;
        alu_ctl = 3'b001;
        branch  = 1'b1;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset low suppresses every write, so an aborted instruction leaves no trace
  assign ctrl.PCWrite       = reset & ((branch & ctrl.Zero) | pc_update);
  assign ctrl.IRWrite       = reset & ir_write;
  assign ctrl.MemWrite      = reset & mem_write;
  assign ctrl.RegWrite      = reset & reg_write;
  assign ctrl.illegal_instr = reset & illegal;
  assign ctrl.AdrSrc        = adr_src;
  assign ctrl.ResultSrc     = result_src;
  assign ctrl.ALUSrcA       = src_a;
  assign ctrl.ALUSrcB       = src_b;
  assign ctrl.ImmSrc        = imm_src;
  assign ctrl.ALUControl    = alu_ctl;
  assign ctrl.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  // One expected cycle of an instruction: state plus every control output
  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic       ill;
  } rec_t;

  rec_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(int st, bit pcw, bit adr, bit mw, bit irw, bit rw,
                              int rs, int sa, int sb, int alu, bit ill);
    rec_t r;
    r.st = 4'(st); r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rw = rw;
    r.rs = 2'(rs); r.sa = 2'(sa); r.sb = 2'(sb); r.alu = 3'(alu); r.ill = ill;
    return r;
  endfunction

  function automatic rec_t observed();
    rec_t r;
    r.st = bus.state; r.pcw = bus.PCWrite; r.adr = bus.AdrSrc; r.mw = bus.MemWrite;
    r.irw = bus.IRWrite; r.rw = bus.RegWrite; r.rs = bus.ResultSrc; r.sa = bus.ALUSrcA;
    r.sb = bus.ALUSrcB; r.alu = bus.ALUControl; r.ill = bus.illegal_instr;
    return r;
  endfunction

  function automatic logic [1:0] imm_exp(logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation an arithmetic instruction asks for
  function automatic int alu_exp(logic [6:0] op, logic [2:0] f3, logic f7);
    if (f3 == 3'd0) return (op == 7'b0110011 && f7) ? 1 : 0;
    if (f3 == 3'd2) return 5;
    if (f3 == 3'd6) return 3;
    if (f3 == 3'd7) return 2;
    return 0;
  endfunction

  // Unrolled cycle trace of one whole instruction
  function automatic void build(logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    bit legal = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111};
    rec_t aluwb = mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, !legal));
    case (op)
      7'b0000011: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      7'b0100011: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, alu_exp(op, f3, f7), 0));
        exp_q.push_back(aluwb);
      end
      7'b0010011: begin
        exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, alu_exp(op, f3, f7), 0));
        exp_q.push_back(aluwb);
      end
      7'b1100011: exp_q.push_back(mk(9, z, 0, 0, 0, 0, 0, 2, 0, 1, 0));
      7'b1101111: begin
        exp_q.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        exp_q.push_back(aluwb);
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge while in FETCH; returns at the next FETCH negedge
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    build(op, f3, f7, z);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("op%07b_f3%0d_cyc%0d", op, f3, i), 32'(observed()), 32'(exp_q[i]));
      chk($sformatf("immsrc_op%07b", op), 32'(bus.ImmSrc), 32'(imm_exp(op)));
    end
    @(negedge clk);
  endtask

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    logic [6:0] rop;
    reset = 1'b0;
    bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    bus.mem_ready = 1'b1;
`endif

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_enables", {27'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite,
                          bus.RegWrite, bus.illegal_instr}, 32'd0);
    end
    reset = 1'b1;

    // Directed instructions (first one also covers the post-reset FETCH)
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);   // lw
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);   // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);   // beq not taken
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);   // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);   // addi with bit 30 set
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0);   // and
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);   // illegal
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);   // sw
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b1);   // jal

    // Reset asserted in MEMWB of a lw: the write is suppressed
    bus.op = 7'b0000011; bus.funct3 = 3'd2;
    repeat (4) @(negedge clk);
    #1 chk("abort_in_memwb", 32'(bus.state), 32'd4);
    reset = 1'b0;
    #1 chk("abort_regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    #1 chk("abort_to_fetch", 32'(bus.state), 32'd0);
    reset = 1'b1;
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);   // or

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    // sw with a stalled FETCH and three wait cycles in MEMWRITE
    bus.op = 7'b0100011; bus.funct3 = 3'd2; bus.mem_ready = 1'b0;
    #1 chk("hs_fetch_stall_irw", {30'd0, bus.IRWrite, bus.PCWrite}, 32'd0);
    @(negedge clk);
    #1 chk("hs_fetch_hold", 32'(bus.state), 32'd0);
    bus.mem_ready = 1'b1;
    #1 chk("hs_fetch_accept", {30'd0, bus.IRWrite, bus.PCWrite}, 32'd3);
    @(negedge clk);
    #1 chk("hs_decode", 32'(bus.state), 32'd1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) bus.mem_ready = 1'b1;
      #1 chk($sformatf("hs_memwrite_%0d", i), {27'd0, bus.state, bus.MemWrite}, 32'h0B);
    end
    @(negedge clk);
    #1 chk("hs_back_to_fetch", 32'(bus.state), 32'd0);
    @(negedge clk);
    #1 chk("hs_decode2", 32'(bus.state), 32'd1);
    // let the sw finish, then resume at a FETCH negedge
    repeat (3) @(negedge clk);
    #1 chk("hs_fetch_again", 32'(bus.state), 32'd0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do rop = 7'($urandom_range(0, 127));
        while (rop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111});
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
